// File: rtl/cache_burst_pkg.sv
// Shared types and derived sizes for the cache line burst controller.
package cache_burst_pkg;

    // Default geometry of the line and the memory port.
    localparam int unsigned DEF_AXI_DATA_WIDTH = 32;
    localparam int unsigned DEF_BLOCK_WIDTH    = 512;
    localparam int unsigned DEF_ADDR_WIDTH     = 64;

    // Number of memory beats needed to move one cache line.
    function automatic int unsigned calc_beats(input int unsigned block_w,
                                               input int unsigned data_w);
        return block_w / data_w;
    endfunction

    // Width of a beat counter that spans 0 .. beats-1.
    function automatic int unsigned calc_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Number of line-offset address bits that are forced to zero.
    function automatic int unsigned calc_ofs_w(input int unsigned block_w);
        return $clog2(block_w / 8);
    endfunction

    localparam int unsigned BEATS = calc_beats(DEF_BLOCK_WIDTH, DEF_AXI_DATA_WIDTH);
    localparam int unsigned CNT_W = calc_cnt_w(BEATS);

    // Burst sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_LOAD = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_RESP = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

endpackage

// File: rtl/cache_burst_ctrl_beat_counter.sv
// Beat counter with synchronous clear, enable and terminal count at BEATS-1.
module beat_counter
    import cache_burst_pkg::*;
#(
    parameter int unsigned NUM_BEATS = BEATS,
    parameter int unsigned CW        = CNT_W
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, and the final beat wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == LAST);

endmodule

// File: rtl/cache_burst_ctrl.sv
// Burst sequencer moving one cache line through the shift register over a
// simplified AXI-style port: refill (read) or writeback (write).
module cache_burst_ctrl
    import cache_burst_pkg::*;
#(
    // BLOCK_WIDTH must be an integer multiple (>= 2) of AXI_DATA_WIDTH.
    parameter int unsigned AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
    parameter int unsigned BLOCK_WIDTH    = DEF_BLOCK_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start_rd,
    input  logic                  i_start_wr,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_ar_valid,
    input  logic                  i_ar_ready,
    input  logic                  i_r_valid,
    output logic                  o_r_ready,
    output logic                  o_aw_valid,
    input  logic                  i_aw_ready,
    output logic                  o_w_valid,
    output logic                  o_w_last,
    input  logic                  i_w_ready,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    output logic                  o_sr_load,
    output logic                  o_sr_shift,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned NUM_BEATS = calc_beats(BLOCK_WIDTH, AXI_DATA_WIDTH);
    localparam int unsigned CW        = calc_cnt_w(NUM_BEATS);
    localparam int unsigned OFS_W     = calc_ofs_w(BLOCK_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << OFS_W) - ADDR_WIDTH'(1));

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  cnt_clr;
    logic                  cnt_tc;
    logic                  sr_shift;

    // Shifts only happen on a completed data handshake.
    assign sr_shift = ((state_q == ST_RD_DATA) && i_r_valid) ||
                      ((state_q == ST_WR_DATA) && i_w_ready);

    beat_counter #(
        .NUM_BEATS (NUM_BEATS),
        .CW        (CW)
    ) u_beat_counter (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_clr  (cnt_clr),
        .i_en   (sr_shift),
        .o_tc   (cnt_tc)
    );

    // Next state, address capture and counter clear.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Writeback has priority so a dirty victim leaves before refill.
                if (i_start_wr) begin
                    state_d = ST_WR_LOAD;
                    addr_d  = i_addr & ADDR_MASK;
                    cnt_clr = 1'b1;
                end else if (i_start_rd) begin
                    state_d = ST_RD_ADDR;
                    addr_d  = i_addr & ADDR_MASK;
                    cnt_clr = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (i_ar_ready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (i_r_valid && cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_WR_LOAD: begin
                state_d = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (i_aw_ready) begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (i_w_ready && cnt_tc) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (i_b_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-address registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Control outputs are decoded from the state so they line up with handshakes.
    assign o_addr     = addr_q;
    assign o_ar_valid = (state_q == ST_RD_ADDR);
    assign o_r_ready  = (state_q == ST_RD_DATA);
    assign o_aw_valid = (state_q == ST_WR_ADDR);
    assign o_w_valid  = (state_q == ST_WR_DATA);
    assign o_w_last   = (state_q == ST_WR_DATA) && cnt_tc;
    assign o_b_ready  = (state_q == ST_WR_RESP);
    assign o_sr_load  = (state_q == ST_WR_LOAD);
    assign o_sr_shift = sr_shift;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_cache_burst_ctrl.sv
// Self-checking bench: a step-queue model of each burst predicts every output.
module tb_cache_burst_ctrl;
    import cache_burst_pkg::*;

    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam logic [AW-1:0] LINE_MASK = ~64'h3F;

    logic          i_clk      = 1'b0;
    logic          i_arst     = 1'b0;
    logic          i_start_rd = 1'b0;
    logic          i_start_wr = 1'b0;
    logic [AW-1:0] i_addr     = '0;
    logic          i_ar_ready = 1'b0;
    logic          i_r_valid  = 1'b0;
    logic          i_aw_ready = 1'b0;
    logic          i_w_ready  = 1'b0;
    logic          i_b_valid  = 1'b0;
    logic [AW-1:0] o_addr;
    logic o_ar_valid, o_r_ready, o_aw_valid, o_w_valid, o_w_last, o_b_ready;
    logic o_sr_load, o_sr_shift, o_busy, o_done;

    cache_burst_ctrl dut (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_start_rd (i_start_rd),
        .i_start_wr (i_start_wr),
        .i_addr     (i_addr),
        .o_addr     (o_addr),
        .o_ar_valid (o_ar_valid),
        .i_ar_ready (i_ar_ready),
        .i_r_valid  (i_r_valid),
        .o_r_ready  (o_r_ready),
        .o_aw_valid (o_aw_valid),
        .i_aw_ready (i_aw_ready),
        .o_w_valid  (o_w_valid),
        .o_w_last   (o_w_last),
        .i_w_ready  (i_w_ready),
        .i_b_valid  (i_b_valid),
        .o_b_ready  (o_b_ready),
        .o_sr_load  (o_sr_load),
        .o_sr_shift (o_sr_shift),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is a list of steps, each waiting for its own handshake.
    localparam int K_NONE = 0, K_AR = 1, K_R = 2, K_LD = 3, K_AW = 4, K_W = 5, K_B = 6, K_DN = 7;
    typedef struct { int kind; int idx; } step_t;
    step_t         q[$];
    logic [AW-1:0] m_addr = '0;

    function automatic bit step_fires(input step_t s);
        case (s.kind)
            K_AR:    return i_ar_ready;
            K_R:     return i_r_valid;
            K_AW:    return i_aw_ready;
            K_W:     return i_w_ready;
            K_B:     return i_b_valid;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            q.delete();
            m_addr = '0;
        end else if (q.size() == 0) begin
            if (i_start_wr) begin
                m_addr = i_addr & LINE_MASK;
                q.push_back('{K_LD, 0});
                q.push_back('{K_AW, 0});
                for (int i = 0; i < int'(BEATS); i++) q.push_back('{K_W, i});
                q.push_back('{K_B, 0});
                q.push_back('{K_DN, 0});
            end else if (i_start_rd) begin
                m_addr = i_addr & LINE_MASK;
                q.push_back('{K_AR, 0});
                for (int i = 0; i < int'(BEATS); i++) q.push_back('{K_R, i});
                q.push_back('{K_DN, 0});
            end
        end else if (step_fires(q[0])) begin
            void'(q.pop_front());
        end
    end

    // Per-cycle comparison of every output against the model.
    bit cmp_en = 1'b0;
    always @(negedge i_clk) begin : cmp
        int k;
        int ix;
        if (cmp_en) begin
            k  = (q.size() != 0) ? q[0].kind : K_NONE;
            ix = (q.size() != 0) ? q[0].idx : 0;
            check_vec("addr", o_addr, m_addr);
            check_bit("ar_valid", o_ar_valid, k == K_AR);
            check_bit("r_ready", o_r_ready, k == K_R);
            check_bit("aw_valid", o_aw_valid, k == K_AW);
            check_bit("w_valid", o_w_valid, k == K_W);
            check_bit("w_last", o_w_last, (k == K_W) && (ix == int'(BEATS) - 1));
            check_bit("b_ready", o_b_ready, k == K_B);
            check_bit("sr_load", o_sr_load, k == K_LD);
            check_bit("sr_shift", o_sr_shift, ((k == K_R) && i_r_valid) || ((k == K_W) && i_w_ready));
            check_bit("busy", o_busy, q.size() != 0);
            check_bit("done", o_done, k == K_DN);
        end
    end

    // Event tallies used by the directed checks.
    int cyc = 0;
    int sh_cnt = 0, done_cnt = 0, ld_cnt = 0, ar_cnt = 0, wlast_acc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) begin
        if (!i_arst) begin
            if (o_sr_shift) sh_cnt <= sh_cnt + 1;
            if (o_done) done_cnt <= done_cnt + 1;
            if (o_sr_load) ld_cnt <= ld_cnt + 1;
            if (o_ar_valid) ar_cnt <= ar_cnt + 1;
            if (o_w_valid && o_w_last && i_w_ready) wlast_acc <= wlast_acc + 1;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_start_rd = 1'b0;
        i_start_wr = 1'b0;
        i_ar_ready = 1'b0;
        i_r_valid  = 1'b0;
        i_aw_ready = 1'b0;
        i_w_ready  = 1'b0;
        i_b_valid  = 1'b0;
    endtask

    // Wait for o_done; lat is the cycle index relative to t0, -1 on timeout.
    task automatic wait_done(input int t0, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (o_busy && n < limit) begin
            tick();
            n++;
        end
        check_bit(name, o_busy, 1'b0);
    endtask

    initial begin
        int t0, s0, d0, l0, a0, w0, lat, n;

        #1 i_arst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) tick();
        check_vec("reset_addr", o_addr, '0);
        check_bit("reset_busy", o_busy, 1'b0);
        check_bit("reset_done", o_done, 1'b0);
        i_arst = 1'b0;
        tick();

        // Zero-wait refill.
        drive_idle();
        i_ar_ready = 1'b1; i_r_valid = 1'b1;
        i_addr = 64'h1234_5678; i_start_rd = 1'b1;
        t0 = cyc; s0 = sh_cnt;
        tick();
        i_start_rd = 1'b0; i_addr = 64'hFFFF_0000_DEAD_BEEF;
        wait_done(t0, 60, lat);
        check_int("rd_latency", lat, 18);
        check_vec("rd_addr", o_addr, 64'h1234_5640);
        tick();
        check_bit("rd_busy_after", o_busy, 1'b0);
        check_int("rd_shifts", sh_cnt - s0, 16);

        // Writeback with toggling w_ready, delayed response.
        drive_idle();
        i_aw_ready = 1'b1; i_start_wr = 1'b1; i_addr = 64'h0000_00AB_CDEF_0123;
        s0 = sh_cnt; w0 = wlast_acc; l0 = ld_cnt;
        tick();
        i_start_wr = 1'b0;
        n = 0;
        while (!o_b_ready && n < 200) begin
            i_w_ready = ~i_w_ready;
            tick();
            n++;
        end
        i_w_ready = 1'b0;
        check_int("wr_shifts", sh_cnt - s0, 16);
        check_int("wr_last_beats", wlast_acc - w0, 1);
        check_int("wr_loads", ld_cnt - l0, 1);
        check_vec("wr_addr", o_addr, 64'h0000_00AB_CDEF_0100);
        tick(); tick();
        check_bit("wr_resp_wait", o_b_ready, 1'b1);
        i_b_valid = 1'b1;
        @(negedge i_clk);
        check_bit("wr_done_not_yet", o_done, 1'b0);
        tick();
        i_b_valid = 1'b0;
        @(negedge i_clk);
        check_bit("wr_done_after_b", o_done, 1'b1);
        tick();

        // Simultaneous starts: writeback wins, read start dropped.
        drive_idle();
        i_ar_ready = 1'b1; i_r_valid = 1'b1; i_aw_ready = 1'b1; i_w_ready = 1'b1; i_b_valid = 1'b1;
        i_start_rd = 1'b1; i_start_wr = 1'b1; i_addr = 64'h40;
        t0 = cyc; s0 = sh_cnt; l0 = ld_cnt; a0 = ar_cnt;
        tick();
        i_start_rd = 1'b0; i_start_wr = 1'b0;
        wait_done(t0, 60, lat);
        check_int("both_latency", lat, 20);
        tick();
        check_int("both_loads", ld_cnt - l0, 1);
        check_int("both_no_ar", ar_cnt - a0, 0);
        check_int("both_shifts", sh_cnt - s0, 16);

        // Address stall on the read channel.
        drive_idle();
        i_r_valid = 1'b1; i_start_rd = 1'b1; i_addr = 64'h8000_0000_0000_007F;
        t0 = cyc; s0 = sh_cnt;
        tick();
        i_start_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bit("ar_held", o_ar_valid, 1'b1);
            tick();
        end
        check_int("ar_stall_no_shift", sh_cnt - s0, 0);
        i_ar_ready = 1'b1;
        wait_done(t0, 60, lat);
        check_int("ar_stall_latency", lat, 23);
        tick();
        check_int("ar_stall_shifts", sh_cnt - s0, 16);

        // Reset after beat 7 of a refill, then a clean writeback.
        drive_idle();
        i_ar_ready = 1'b1; i_r_valid = 1'b1; i_start_rd = 1'b1; i_addr = 64'h1000;
        s0 = sh_cnt;
        tick();
        i_start_rd = 1'b0;
        n = 0;
        while ((sh_cnt - s0) < 7 && n < 50) begin
            tick();
            n++;
        end
        check_int("pre_reset_shifts", sh_cnt - s0, 7);
        i_arst = 1'b1;
        #1;
        check_bit("arst_busy", o_busy, 1'b0);
        check_bit("arst_r_ready", o_r_ready, 1'b0);
        check_bit("arst_shift", o_sr_shift, 1'b0);
        check_vec("arst_addr", o_addr, '0);
        d0 = done_cnt;
        tick();
        i_arst = 1'b0;
        repeat (25) tick();
        check_int("arst_no_done", done_cnt - d0, 0);
        i_aw_ready = 1'b1; i_w_ready = 1'b1; i_b_valid = 1'b1; i_start_wr = 1'b1;
        t0 = cyc; s0 = sh_cnt;
        tick();
        i_start_wr = 1'b0;
        wait_done(t0, 60, lat);
        check_int("post_reset_wr_latency", lat, 20);
        tick();
        check_int("post_reset_wr_shifts", sh_cnt - s0, 16);

        // Starts during an active burst are ignored.
        drive_idle();
        i_ar_ready = 1'b1; i_r_valid = 1'b1; i_start_rd = 1'b1; i_addr = 64'h2000;
        d0 = done_cnt;
        tick();
        i_start_rd = 1'b0;
        repeat (5) tick();
        i_start_rd = 1'b1; i_start_wr = 1'b1; i_addr = 64'h3000;
        tick();
        i_start_rd = 1'b0; i_start_wr = 1'b0;
        wait_idle("ignore_start_idle", 60);
        repeat (10) tick();
        check_int("ignore_start_dones", done_cnt - d0, 1);
        check_vec("ignore_start_addr", o_addr, 64'h2000);
        check_bit("ignore_start_busy", o_busy, 1'b0);

        // Randomized traffic against the model.
        drive_idle();
        d0 = done_cnt;
        n = 0;
        while ((done_cnt - d0) < 30 && n < 6000) begin
            i_ar_ready = ($urandom_range(0, 3) != 0);
            i_r_valid  = ($urandom_range(0, 3) != 0);
            i_aw_ready = ($urandom_range(0, 2) != 0);
            i_w_ready  = ($urandom_range(0, 3) != 0);
            i_b_valid  = ($urandom_range(0, 2) == 0);
            i_start_rd = ($urandom_range(0, 5) == 0);
            i_start_wr = ($urandom_range(0, 5) == 0);
            i_addr     = {$urandom, $urandom};
            i_arst     = ($urandom_range(0, 399) == 0);
            tick();
            n++;
        end
        i_arst = 1'b0;
        drive_idle();
        i_ar_ready = 1'b1; i_r_valid = 1'b1; i_aw_ready = 1'b1; i_w_ready = 1'b1; i_b_valid = 1'b1;
        wait_idle("random_drain", 100);
        check_bit("random_enough_bursts", (done_cnt - d0) >= 30, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_burst_ctrl.md
# cache_burst_ctrl

Sequences the cache-line shift register between a cache and a simplified AXI-style memory port. It runs one burst per request: a refill (read) or a writeback (write) of one BLOCK_WIDTH line as BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH beats. It drives the shift register's parallel-load and shift enables and counts beats. It signals completion to the cache FSM.

## Interface
- AXI_DATA_WIDTH, 32, beat width in bits.
- BLOCK_WIDTH, 512, cache-line width in bits; must be an integer multiple (≥2) of AXI_DATA_WIDTH.
- ADDR_WIDTH, 64, byte address width.
- i_clk  in  1  clock; all logic is rising-edge.
- i_arst  in  1  reset; asynchronous and active-high.
- i_start_rd  in  1  refill request, sampled in IDLE only.
- i_start_wr  in  1  writeback request, sampled in IDLE only.
- i_addr  in  ADDR_WIDTH  line address, captured on accepted start.
- o_addr  out  ADDR_WIDTH  captured address, low log2(BLOCK_WIDTH/8) bits forced to 0.
- o_ar_valid  out  1  read address valid.
- i_ar_ready  in  1  read address accepted.
- i_r_valid  in  1  read data beat present (data goes straight to shift register serial input).
- o_r_ready  out  1  ready for read beat.
- o_aw_valid  out  1  write address valid.
- i_aw_ready  in  1  write address accepted.
- o_w_valid  out  1  write beat valid (data is shift register LSB beat).
- o_w_last  out  1  final write beat.
- i_w_ready  in  1  write beat accepted.
- i_b_valid  in  1  write response.
- o_b_ready  out  1  ready for write response.
- o_sr_load  out  1  shift register parallel load (line from cache).
- o_sr_shift  out  1  shift register shift-in enable.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_LOAD, WR_ADDR, WR_DATA, WR_RESP, DONE.
- IDLE: if i_start_wr goes to WR_LOAD, else if i_start_rd goes to RD_ADDR. Write wins on simultaneous start because writeback precedes refill. Both cases capture i_addr and clear the beat counter.
- RD_ADDR: o_ar_valid=1; on i_ar_ready goes to RD_DATA.
- RD_DATA: o_r_ready=1; o_sr_shift = i_r_valid. Each beat increments the counter. The BEATS-th beat goes to DONE. The first beat lands in the LSB slot after all shifts.
- WR_LOAD: o_sr_load=1 for exactly one cycle, then WR_ADDR.
- WR_ADDR: o_aw_valid=1; on i_aw_ready goes to WR_DATA.
- WR_DATA: o_w_valid=1; o_sr_shift = i_w_ready. Each accepted beat increments the counter. o_w_last=1 when counter==BEATS-1. An accepted last beat goes to WR_RESP.
- WR_RESP: o_b_ready=1; on i_b_valid goes to DONE. Response code is ignored.
- DONE: o_done=1 for one cycle, then IDLE.
- o_sr_load and o_sr_shift are never high together. No shift occurs outside RD_DATA/WR_DATA.
- Beat counter is $clog2(BEATS) bits and wraps to 0 on the final beat.
- Starts outside IDLE are ignored and not queued.
- Valid/address outputs hold stable until accepted. o_addr holds from capture until the next accepted start.

## Timing
- Reset value: state IDLE, counter 0, o_addr 0. Every 1-bit output is 0.
- Reset mid-burst returns to IDLE immediately (async). The partial burst is abandoned and no o_done is issued.
- Control outputs are decoded combinationally from the state register plus the same-cycle ready/valid inputs. o_sr_shift and o_sr_load therefore coincide with the handshake cycle.
- Start to o_ar_valid/o_sr_load: 1 cycle.
- Minimum refill: 1 (RD_ADDR) + BEATS + 1 (DONE) = 18 cycles at defaults with zero-wait responses.
- Minimum writeback: 1 + 1 + BEATS + 1 + 1 = 20 cycles.
- Back-to-back: the cycle after DONE is IDLE and can accept a new start. Throughput is therefore one burst per latency + 1 cycle.

## Structure
- Shared package cache_burst_pkg holds:
  - the state enum type;
  - localparam BEATS and the counter width, derived from the parameters.
- Sub-module beat_counter holds a clear, an enable and a terminal-count output at BEATS-1.
- The shift register itself is instantiated by the parent cache wrapper, not inside this block.

## Test plan
- Refill, zero-wait: i_start_rd with i_addr=0x1234_5678. Required: o_addr=0x1234_5640; 16 o_sr_shift pulses; o_done in cycle 18; o_busy low in cycle 19.
- Writeback with i_w_ready toggling 1/0: exactly 16 shifts, and o_w_last only on the 16th valid beat. o_w_valid is held while i_w_ready=0. o_done follows i_b_valid by 1 cycle.
- Simultaneous i_start_rd=i_start_wr=1: writeback runs (o_sr_load asserts). The read start is dropped, and o_ar_valid never asserts.
- i_ar_ready held 0 for 5 cycles: o_ar_valid stays high and no shifts occur. Data then completes normally.
- i_arst asserted after beat 7 of a refill: all outputs go to 0 at once and no o_done follows. A subsequent writeback completes with exactly 16 shifts.
- i_start_rd pulsed during an active burst: ignored, exactly one o_done, and no second burst.
